// File: rtl/wire_use_arbiter_pkg.sv
// Shared types and defaults for the wire_use arbiter: FSM state encoding,
// default parameters and the round-robin pointer advance.
package wire_use_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2
    } state_e;

    localparam int unsigned DefNumReq  = 4;
    localparam int unsigned DefIdW     = 2;
    localparam int unsigned DefHoldCyc = 2;
    // Hold counter must cover HOLD_CYC-1 for the legal range 1..15.
    localparam int unsigned CntW       = 4;

    function automatic int unsigned wrap_inc(input int unsigned id, input int unsigned n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/wire_use_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or above ptr_i,
// wrapping around. Returns one-hot grant, encoded ID and an any-valid flag.
module wire_use_arbiter_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    id_o,
    output logic               valid_o
);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W:0]      sum;

    always_comb begin
        // Bit i of rot is request (ptr_i + i) mod NUM_REQ.
        rot     = NUM_REQ'({req_i, req_i} >> ptr_i);
        sum     = '0;
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && rot[i]) begin
                valid_o = 1'b1;
                sum     = {1'b0, ptr_i} + (ID_W+1)'(i);
                if (sum >= (ID_W+1)'(NUM_REQ)) begin
                    sum = sum - (ID_W+1)'(NUM_REQ);
                end
                id_o = sum[ID_W-1:0];
            end
        end
        gnt_o = valid_o ? (NUM_REQ'(1) << id_o) : '0;
    end

endmodule

// File: rtl/wire_use_arbiter.sv
// Round-robin arbiter sharing one external wire_use unit between NUM_REQ
// requesters: capture winner's {A,B,D}, hold HOLD_CYC cycles, return tagged E.
module wire_use_arbiter
    import wire_use_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned ID_W     = DefIdW,
    parameter int unsigned HOLD_CYC = DefHoldCyc
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [3*NUM_REQ-1:0] abd_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic                 A_o,
    output logic                 B_o,
    output logic                 D_o,
    input  logic                 E_i,
    output logic                 rsp_valid_o,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic                 rsp_e_o
);

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    win_q;
    logic [CntW-1:0]    cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [2:0]         abd_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_e_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;
    logic [2:0]         pick_abd;

    wire_use_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .id_o    (pick_id),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_abd = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_gnt[k]) begin
                pick_abd = abd_i[3*k +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            abd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_e_q     <= 1'b0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        abd_q   <= pick_abd;
                        gnt_q   <= pick_gnt;
                        win_q   <= pick_id;
                        cnt_q   <= CntW'(HOLD_CYC - 1);
                        state_q <= StDrive;
                    end
                end
                StDrive: begin
                    if (cnt_q == '0) begin
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StSample: begin
                    rsp_e_q     <= E_i;
                    rsp_id_q    <= win_q;
                    rsp_valid_q <= 1'b1;
                    // Just-served requester drops to lowest priority.
                    ptr_q       <= ID_W'(wrap_inc(32'(win_q), NUM_REQ));
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign A_o         = abd_q[2];
    assign B_o         = abd_q[1];
    assign D_o         = abd_q[0];
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_e_o     = rsp_e_q;

endmodule

// File: tb/tb_wire_use_arbiter.sv
// Scoreboard bench for wire_use_arbiter: directed stimulus pushes expected
// grants/responses; a negedge monitor pops and compares whatever the DUT emits.
module tb_wire_use_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int HC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [3*NR-1:0] abd;
    logic [NR-1:0]   gnt;
    logic            a, b, d, e;
    logic            rsp_valid, rsp_e;
    logic [IW-1:0]   rsp_id;
    logic            force_en, force_val;

    always #5 clk = ~clk;

    // Stand-in for the shared wire_use unit.
    function automatic logic wire_use_f(input logic fa, input logic fb, input logic fd);
        return (fa & fb) | fd;
    endfunction

    assign e = force_en ? force_val : wire_use_f(a, b, d);

    wire_use_arbiter #(
        .NUM_REQ  (NR),
        .ID_W     (IW),
        .HOLD_CYC (HC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .abd_i       (abd),
        .gnt_o       (gnt),
        .A_o         (a),
        .B_o         (b),
        .D_o         (d),
        .E_i         (e),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_e_o     (rsp_e)
    );

    typedef struct packed {logic [IW-1:0] id; logic [2:0] abd;} gexp_t;
    typedef struct packed {logic [IW-1:0] id; logic e;} rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    gcyc[$];
    int    total = 0, bad = 0, cyc = 0, ngnt = 0, nrsp = 0, last_gcyc = 0;
    gexp_t g_e;
    rexp_t r_e;
    logic [NR-1:0] oh;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != '0) begin
                ngnt++;
                gcyc.push_back(cyc);
                last_gcyc = cyc;
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    g_e = gq.pop_front();
                    oh  = 4'b0001 << g_e.id;
                    chk("gnt_onehot", 32'(gnt), 32'(oh));
                    chk("gnt_abd", 32'({a, b, d}), 32'(g_e.abd));
                end
            end
            if (rsp_valid) begin
                nrsp++;
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    r_e = rq.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(r_e.id));
                    chk("rsp_e", 32'(rsp_e), 32'(r_e.e));
                    chk("rsp_latency", 32'(cyc - last_gcyc), 32'(HC + 1));
                end
            end
        end
    end

    function automatic logic [2:0] trip(input int k);
        return abd[3*k +: 3];
    endfunction

    task automatic push(input int id, input logic [2:0] t, input logic forced, input logic fv);
        gq.push_back('{id: IW'(id), abd: t});
        rq.push_back('{id: IW'(id), e: forced ? fv : wire_use_f(t[2], t[1], t[0])});
    endtask

    task automatic wait_gnts(input int target, input int budget, input string nm);
        int n = 0;
        while (ngnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (ngnt < target) chk(nm, 32'(ngnt), 32'(target));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((gq.size() != 0 || rq.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (gq.size() != 0 || rq.size() != 0) begin
            chk("drain_timeout", 32'(gq.size() + rq.size()), 32'd0);
            gq.delete();
            rq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, base, n0;
        force_en  = 1'b1;
        force_val = 1'($urandom);
        rst_n     = 1'b0;
        req       = 4'($urandom);
        abd       = 12'($urandom);
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_abd", 32'({a, b, d}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_e", 32'(rsp_e), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_gnt", 32'(gnt), 32'd0);
        chk("rst_hold_abd", 32'({a, b, d}), 32'd0);
        req   = '0;
        abd   = '0;
        rst_n = 1'b1;

        // Idle: no requests, nothing must come out.
        repeat (10) @(posedge clk);
        #1;
        chk("idle_gnt_cnt", 32'(ngnt), 32'd0);
        chk("idle_rsp_cnt", 32'(nrsp), 32'd0);

        // Single request from ID 2 with E forced high.
        force_en  = 1'b1;
        force_val = 1'b1;
        abd       = 12'b000_110_000_000;
        push(2, 3'b110, 1'b1, 1'b1);
        gcyc.delete();
        c0  = cyc;
        req = 4'b0100;
        wait_gnts(1, 10, "single_gnt_timeout");
        req = '0;
        if (gcyc.size() > 0) chk("single_gnt_lat", 32'(gcyc[0]), 32'(c0 + 1));
        drain(20);

        // Fairness from reset: all requesting.
        rst_n = 1'b0;
        #1;
        rst_n    = 1'b1;
        force_en = 1'b0;
        abd      = 12'b111_010_101_011;
        gcyc.delete();
        base = ngnt;
        for (int i = 0; i < 6; i++) push(i % NR, trip(i % NR), 1'b0, 1'b0);
        req = 4'b1111;
        wait_gnts(base + 6, 40, "fair_gnt_timeout");
        req = '0;
        for (int i = 1; i < 6; i++) begin
            if (gcyc.size() > i) chk("fair_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'(HC + 2));
        end
        drain(20);

        // Skip and wrap: serve 3, then 1001 alternates 0,3,0,3.
        base = ngnt;
        push(3, trip(3), 1'b0, 1'b0);
        req = 4'b1000;
        wait_gnts(base + 1, 10, "skip_gnt3_timeout");
        req = '0;
        drain(20);
        base = ngnt;
        push(0, trip(0), 1'b0, 1'b0);
        push(3, trip(3), 1'b0, 1'b0);
        push(0, trip(0), 1'b0, 1'b0);
        push(3, trip(3), 1'b0, 1'b0);
        req = 4'b1001;
        wait_gnts(base + 4, 30, "wrap_gnt_timeout");
        req = '0;
        drain(20);

        // Operand stability: alter the granted requester's triple during DRIVE.
        abd  = 12'b000_000_011_000;
        base = ngnt;
        push(1, 3'b011, 1'b0, 1'b0);
        req = 4'b0010;
        wait_gnts(base + 1, 10, "stab_gnt_timeout");
        abd[5:3] = 3'b100;
        req      = '0;
        @(posedge clk);
        #1;
        chk("hold_abd", 32'({a, b, d}), 32'b011);
        drain(20);

        // Reset in the middle of DRIVE drops the transaction.
        abd  = 12'b001_001_001_001;
        base = ngnt;
        push(2, 3'b001, 1'b0, 1'b0);
        req = 4'b1111;
        wait_gnts(base + 1, 10, "mid_gnt_timeout");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_abd", 32'({a, b, d}), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_rsp_e", 32'(rsp_e), 32'd0);
        rq.delete();
        n0 = nrsp;
        repeat (3) @(posedge clk);
        #1;
        base = ngnt;
        push(0, 3'b001, 1'b0, 1'b0);
        rst_n = 1'b1;
        wait_gnts(base + 1, 10, "post_rst_gnt_timeout");
        req = '0;
        chk("mid_rst_no_rsp", 32'(nrsp), 32'(n0));
        drain(20);

        chk("queues_empty", 32'(gq.size() + rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
